if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/singlecycle_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 41 ++++
 rtl/if_prefetch.sv | 74 +++++++
 tb/tb_if_prefetch.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/singlecycle_pkg.sv
// singlecycle_pkg: shared fetch constants and the prefetch queue entry type.
package singlecycle_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush and occupancy count.
module fetch_fifo
    import singlecycle_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  fetch_entry_t  i_data,
    input  logic          i_pop,
    output fetch_entry_t  o_head,
    output logic [CW-1:0] o_count
);
    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_q + AW'(i_pop);
            wr_q  <= wr_q + AW'(i_push);
            cnt_q <= cnt_q + CW'(i_push) - CW'(i_pop);
        end
    end

    // Storage needs no reset: entries are only observed while counted.
    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_q] <= i_data;
    end

    assign o_head  = mem_q[rd_q];
    assign o_count = cnt_q;
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: credit-based instruction prefetcher with redirect flush and stale-response discard.
module if_prefetch
    import singlecycle_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_mem_req_vld,
    output logic [31:0] o_mem_req_addr,
    input  logic        i_mem_req_rdy,
    input  logic        i_mem_rsp_vld,
    input  logic [31:0] i_mem_rsp_data,
    output logic        o_inst_vld,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_inst_rdy
);
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = FIFO_DEPTH[CW:0];

    logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
    logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d, fifo_count;
    logic          accept, rsp_ok, push, pop, has_inst;
    fetch_entry_t  head;

    always_comb begin
        target         = {i_redirect_pc[31:2], 2'b00};
        has_inst       = fifo_count != '0;
        o_mem_req_vld  = i_rst_n & !i_redirect & (({1'b0, inflight_q} + {1'b0, fifo_count}) < DEPTH_W);
        o_mem_req_addr = fetch_pc_q;
        o_inst_vld     = i_rst_n & has_inst & !i_redirect;
        o_inst         = has_inst ? head.inst : '0;
        o_pc           = has_inst ? head.pc : '0;
        accept         = o_mem_req_vld & i_mem_req_rdy;
        rsp_ok         = i_mem_rsp_vld & (inflight_q != '0);
        push           = rsp_ok & !i_redirect & (discard_q == '0);
        pop            = o_inst_vld & i_inst_rdy;
        inflight_d     = inflight_q + CW'(accept) - CW'(rsp_ok);
        fetch_pc_d     = i_redirect ? target : fetch_pc_q + (accept ? 32'd4 : 32'd0);
        rsp_pc_d       = i_redirect ? target : rsp_pc_q + (push ? 32'd4 : 32'd0);
        // Every request still outstanding at a redirect belongs to the old path.
        discard_d      = i_redirect ? inflight_q - CW'(rsp_ok)
                                    : discard_q - CW'(rsp_ok & (discard_q != '0));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_redirect),
        .i_push  (push),
        .i_data  ('{pc: rsp_pc_q, inst: i_mem_rsp_data}),
        .i_pop   (pop),
        .o_head  (head),
        .o_count (fifo_count)
    );
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed scenarios against a queue-based reference of the prefetcher.
module tb_if_prefetch;
    import singlecycle_pkg::*;
    localparam int DEPTH = 4;

    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_mem_req_vld, i_mem_req_rdy = 1'b0, i_mem_rsp_vld = 1'b0;
    logic [31:0] o_mem_req_addr, i_mem_rsp_data = '0;
    logic        o_inst_vld, i_inst_rdy = 1'b0;
    logic [31:0] o_inst, o_pc;

    if_prefetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .o_mem_req_vld  (o_mem_req_vld),
        .o_mem_req_addr (o_mem_req_addr),
        .i_mem_req_rdy  (i_mem_req_rdy),
        .i_mem_rsp_vld  (i_mem_rsp_vld),
        .i_mem_rsp_data (i_mem_rsp_data),
        .o_inst_vld     (o_inst_vld),
        .o_inst         (o_inst),
        .o_pc           (o_pc),
        .i_inst_rdy     (i_inst_rdy)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0, failures = 0, cyc = 0;
    bit          en = 1'b0, mem_hold = 1'b0;
    logic [31:0] pend[$], req_log[$], pc_log[$];
    int          pop_cyc[$];
    int          m_infl = 0, m_disc = 0;
    logic [31:0] m_fpc = '0, m_rpc = '0;
    logic [63:0] m_q[$];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Reference: outputs from model state and current inputs, then advance the model.
    always @(negedge i_clk) begin : cmp
        logic        ev, eiv, rok;
        logic [31:0] ei, ep;
        cyc++;
        ev  = i_rst_n && !i_redirect && (m_infl + m_q.size() < DEPTH);
        eiv = i_rst_n && (m_q.size() != 0) && !i_redirect;
        ei  = (m_q.size() != 0) ? m_q[0][31:0] : 32'h0;
        ep  = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
        if (en) begin
            chk("req_vld", {31'h0, o_mem_req_vld}, {31'h0, ev});
            chk("req_addr", o_mem_req_addr, m_fpc);
            chk("inst_vld", {31'h0, o_inst_vld}, {31'h0, eiv});
            chk("inst", o_inst, ei);
            chk("pc", o_pc, ep);
            if (o_inst_vld) chk("inst_data", o_inst, mdata(o_pc));
        end
        if (i_rst_n && o_mem_req_vld && i_mem_req_rdy) req_log.push_back(o_mem_req_addr);
        if (o_inst_vld && i_inst_rdy) begin
            pc_log.push_back(o_pc);
            pop_cyc.push_back(cyc);
        end
        rok = i_mem_rsp_vld && (m_infl > 0);
        if (!i_rst_n) begin
            m_infl = 0; m_disc = 0; m_fpc = '0; m_rpc = '0;
            m_q.delete();
        end else if (i_redirect) begin
            if (rok) m_infl--;
            m_disc = m_infl;
            m_q.delete();
            m_fpc = {i_redirect_pc[31:2], 2'b00};
            m_rpc = m_fpc;
        end else begin
            if (eiv && i_inst_rdy) void'(m_q.pop_front());
            if (rok) begin
                m_infl--;
                if (m_disc > 0) m_disc--;
                else begin
                    m_q.push_back({m_rpc, i_mem_rsp_data});
                    m_rpc += 32'd4;
                end
            end
            if (ev && i_mem_req_rdy) begin
                m_infl++;
                m_fpc += 32'd4;
            end
        end
    end

    // Memory: answers accepted requests in order, earliest the following cycle.
    task automatic step(input int n = 1);
        bit rs;
        repeat (n) begin
            @(negedge i_clk);
            rs = i_rst_n;
            if (rs && o_mem_req_vld && i_mem_req_rdy) pend.push_back(o_mem_req_addr);
            @(posedge i_clk);
            #1;
            i_mem_rsp_vld  = 1'b0;
            i_mem_rsp_data = '0;
            if (!rs) pend.delete();
            else if (!mem_hold && pend.size() != 0) begin
                i_mem_rsp_vld  = 1'b1;
                i_mem_rsp_data = mdata(pend.pop_front());
            end
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        pc_log.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset();
        i_rst_n    = 1'b0;
        i_redirect = 1'b0;
        step(2);
        i_rst_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        do_reset();
        en = 1'b1;
        i_mem_req_rdy = 1'b1;
        i_inst_rdy    = 1'b1;
        step(8);
        chk("stream_req0", req_log[0], 32'h0);
        chk("stream_req1", req_log[1], 32'h4);
        chk("stream_req2", req_log[2], 32'h8);
        chk("stream_req3", req_log[3], 32'hC);
        chk("stream_pc0", pc_log[0], 32'h0);
        chk("stream_pc1", pc_log[1], 32'h4);
        chk("stream_pc2", pc_log[2], 32'h8);
        chk("stream_pops", pc_log.size(), 6);
        chk("stream_consec", pop_cyc[1] - pop_cyc[0], 1);

        i_inst_rdy = 1'b0;
        do_reset();
        step(10);
        chk("stall_reqs", req_log.size(), 4);
        #1;
        chk("stall_vld", {31'h0, o_mem_req_vld}, 32'h0);
        i_inst_rdy = 1'b1;
        step(8);
        chk("stall_pc0", pc_log[0], 32'h0);
        chk("stall_pc1", pc_log[1], 32'h4);
        chk("stall_pc2", pc_log[2], 32'h8);
        chk("stall_pc3", pc_log[3], 32'hC);
        chk("stall_resume", req_log[4], 32'h10);

        mem_hold = 1'b1;
        do_reset();
        step(3);
        chk("redir_inflight", req_log.size(), 3);
        i_redirect = 1'b1; i_redirect_pc = 32'h103;
        step(1);
        i_redirect = 1'b0; mem_hold = 1'b0;
        clear_logs();
        step(10);
        chk("redir_req", req_log[0], 32'h100);
        chk("redir_pc", pc_log[0], 32'h100);

        mem_hold = 1'b1;
        do_reset();
        step(2);
        i_mem_req_rdy = 1'b0; mem_hold = 1'b0;
        step(1);
        i_redirect = 1'b1; i_redirect_pc = 32'h200; mem_hold = 1'b1;
        step(1);
        i_redirect = 1'b0; i_mem_req_rdy = 1'b1; mem_hold = 1'b0;
        clear_logs();
        step(8);
        chk("redir_rsp_req", req_log[0], 32'h200);
        chk("redir_rsp_pc", pc_log[0], 32'h200);

        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFF8;
        step(1);
        i_redirect = 1'b0;
        clear_logs();
        step(6);
        chk("wrap_req0", req_log[0], 32'hFFFF_FFF8);
        chk("wrap_req1", req_log[1], 32'hFFFF_FFFC);
        chk("wrap_req2", req_log[2], 32'h0);

        clear_logs();
        i_redirect = 1'b1; i_redirect_pc = 32'h300;
        step(1);
        i_redirect_pc = 32'h400;
        step(2);
        chk("hold_noreq", req_log.size(), 0);
        i_redirect = 1'b0;
        step(5);
        chk("hold_last", req_log[0], 32'h400);

        i_inst_rdy = 1'b0;
        do_reset();
        step(4);
        #1;
        chk("rst_full_vld", {31'h0, o_inst_vld}, 32'h1);
        i_rst_n = 1'b0;
        step(1);
        i_rst_n = 1'b1;
        clear_logs();
        #1;
        chk("rst_inst_vld", {31'h0, o_inst_vld}, 32'h0);
        chk("rst_req_addr", o_mem_req_addr, 32'h0);
        i_inst_rdy = 1'b1;
        step(4);
        chk("rst_first_req", req_log[0], 32'h0);
        chk("rst_first_pc", pc_log[0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
